// File: rtl/uart_pkg.sv
// Shared types and register map for the UART transmit peripheral.
// The UART_TX_PARITY_EN macro adds the PARITY state and sets the STATUS parity flag.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] TXDATA_OFF  = 4'h0;
    localparam logic [3:0] STATUS_OFF  = 4'h4;
    localparam logic [3:0] BAUDDIV_OFF = 4'h8;

    localparam int STAT_BUSY = 0;
    localparam int STAT_HOLD = 1;
    localparam int STAT_PAR  = 2;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/uart_tx_periph_if.sv
// Peripheral load/store bus between the address decoder (master) and the UART (slave).
// Read data is combinational and writes are never backpressured.
interface uart_tx_periph_if #(
    parameter int DW = 32
);
    logic          cs_uart_i;
    logic          we_i;
    logic [DW-1:0] addr_i;
    logic [DW-1:0] data_store_i;
    logic [3:0]    mask_i;
    logic [DW-1:0] data_load_o;

    modport master (
        output cs_uart_i, we_i, addr_i, data_store_i, mask_i,
        input  data_load_o
    );

    modport slave (
        input  cs_uart_i, we_i, addr_i, data_store_i, mask_i,
        output data_load_o
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick on the last of div+1 cycles; div is sampled only at bit boundaries.
// Restart holds the count at zero; no backpressure.
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic [15:0] div,
    output logic        tick
);
    logic [15:0] r_cnt;
    logic [15:0] r_div;

    // Latching div here makes a mid-frame BAUDDIV write wait for the next bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
            r_div <= 16'd0;
        end else if (restart || tick) begin
            r_cnt <= 16'd0;
            r_div <= div;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign tick = !restart && (r_cnt == r_div);

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a one-byte hold register; the UART_TX_PARITY_EN macro adds an even parity bit.
// tx_o falls 2 cycles after a write to an idle block; a TXDATA write to a full hold register is dropped.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int          DW          = 32,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_periph_if.slave  bus,
    output logic             tx_o,
    output logic             tx_done_o
);
    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic [7:0]  r_shift;
    logic [2:0]  r_idx;
    logic [15:0] r_baud;
    logic        r_tx;
    logic        r_tx_done;

    logic        w_wr;
    logic [1:0]  w_sel;
    logic        w_wr_tx;
    logic        w_wr_baud;
    logic        w_tick;
    logic        w_take;
    logic        w_busy;
    logic        w_line;
    logic        w_done;
    logic [DW-1:0] w_rdata;
    logic        w_unused;

    assign w_wr      = bus.cs_uart_i && bus.we_i;
    assign w_sel     = bus.addr_i[3:2];
    assign w_wr_tx   = w_wr && (w_sel == TXDATA_OFF[3:2]) && bus.mask_i[0];
    assign w_wr_baud = w_wr && (w_sel == BAUDDIV_OFF[3:2]);
    assign w_busy    = (r_state != ST_IDLE);
    assign w_take    = r_hold_full && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick));
    assign w_unused  = &{1'b0, bus.addr_i[DW-1:4], bus.addr_i[1:0],
                         bus.data_store_i[DW-1:16], bus.mask_i[3:2]};

    uart_baud_gen u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (r_state == ST_IDLE),
        .div     (r_baud),
        .tick    (w_tick)
    );

    // A write landing in the same cycle the hold register drains takes the freed slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold      <= 8'd0;
            r_hold_full <= 1'b0;
            r_baud      <= DEFAULT_DIV;
        end else begin
            if (w_wr_tx && (!r_hold_full || w_take)) begin
                r_hold      <= bus.data_store_i[7:0];
                r_hold_full <= 1'b1;
            end else if (w_take) begin
                r_hold_full <= 1'b0;
            end
            if (w_wr_baud && bus.mask_i[0]) r_baud[7:0]  <= bus.data_store_i[7:0];
            if (w_wr_baud && bus.mask_i[1]) r_baud[15:8] <= bus.data_store_i[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift   <= 8'd0;
            r_idx     <= 3'd0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            if (w_take) r_shift <= r_hold;
            if (r_state != ST_DATA) r_idx <= 3'd0;
            else if (w_tick)        r_idx <= r_idx + 3'd1;
            r_tx      <= w_line;
            r_tx_done <= w_done;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_hold_full) w_state_nxt = ST_START;
            ST_START: if (w_tick) w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_tick && (r_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (w_tick) w_state_nxt = ST_STOP;
`endif
            ST_STOP:  if (w_tick) w_state_nxt = r_hold_full ? ST_START : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Line level for the current state; registered one cycle before reaching tx_o.
    always_comb begin
        w_line = 1'b1;
        w_done = 1'b0;
        case (r_state)
            ST_START:  w_line = 1'b0;
            ST_DATA:   w_line = r_shift[r_idx];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_line = ^r_shift;
`endif
            ST_STOP:   w_done = w_tick;
            default:   w_line = 1'b1;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        if (bus.cs_uart_i) begin
            case (w_sel)
                STATUS_OFF[3:2]: begin
                    w_rdata[STAT_BUSY] = w_busy;
                    w_rdata[STAT_HOLD] = r_hold_full;
                    w_rdata[STAT_PAR]  = PARITY_EN;
                end
                BAUDDIV_OFF[3:2]: w_rdata[15:0] = r_baud;
                default:          w_rdata = '0;
            endcase
        end
    end

    assign bus.data_load_o = w_rdata;
    assign tx_o            = r_tx;
    assign tx_done_o       = r_tx_done;

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 The block SHALL have parameter DW, default 32, bus data width.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 16'd867, reset baud divisor (100 MHz / 115200 - 1).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset: clk input 1, rst_n input 1.
REQ-004 cs_uart_i  input  1  chip select from the peripheral address decoder.
REQ-005 we_i  input  1  store strobe; a write occurs when cs_uart_i and we_i are both 1 on a clk edge.
REQ-006 addr_i  input  DW  byte address; only addr_i[3:2] selects the register.
REQ-007 data_store_i  input  DW  store data.
REQ-008 mask_i  input  4  byte-lane write mask; lane 0 is bits 7:0.
REQ-009 data_load_o  output  DW  combinational read data; 0 when cs_uart_i is 0.
REQ-010 tx_o  output  1  serial line; idles high.
REQ-011 tx_done_o  output  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-012 The register map SHALL be: offset 0x0 TXDATA (W, byte lane 0); 0x4 STATUS (R: bit0 busy, bit1 hold_full, other bits 0); 0x8 BAUDDIV (R/W, bits 15:0, lanes 0-1); 0xC reserved (reads 0, writes ignored).
REQ-013 Masked-off lanes SHALL NOT be written; a TXDATA write with mask_i[0]=0 SHALL be ignored.
REQ-014 A TXDATA write SHALL load a one-entry hold register and set hold_full.
REQ-015 A TXDATA write while hold_full=1 SHALL be dropped, leaving the hold register and hold_full unchanged.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, STOP.
REQ-017 From IDLE with hold_full=1, the FSM SHALL move the hold register to the shift register, clear hold_full, and enter START on the next edge.
REQ-018 If hold_full is cleared and a TXDATA write occurs in the same cycle, the write SHALL win, leaving hold_full=1 with the new byte.
REQ-019 Each bit period SHALL last BAUDDIV+1 clk cycles, timed by a counter reset to 0 on entry to each bit; BAUDDIV=0 SHALL give a 1-cycle bit.
REQ-020 START SHALL drive tx_o=0 for one bit period.
REQ-021 DATA SHALL send 8 bits LSB first using a 3-bit index; after index 7 it SHALL go to STOP.
REQ-022 STOP SHALL drive tx_o=1 for one bit period, then enter IDLE, or START directly if hold_full=1 (back-to-back, no idle gap).
REQ-023 busy SHALL be 1 in every state other than IDLE.
REQ-024 A BAUDDIV write during a frame SHALL take effect at the next bit boundary; the current bit period SHALL be unaffected.
REQ-025 Latency SHALL be fixed: tx_o falls 2 cycles after the edge that captures a TXDATA write into an idle, empty block.

Reset
REQ-026 While rst_n=0 at a clk edge, the block SHALL set: state IDLE, tx_o=1, tx_done_o=0, hold_full=0, BAUDDIV=DEFAULT_DIV, and the counters and shift register to 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately; tx_o SHALL be 1 on the edge after reset and no partial stop bit SHALL be sent.

Configuration
REQ-028 The macro UART_TX_PARITY_EN SHALL compile in a PARITY state between DATA and STOP that sends the even parity bit (XOR of the 8 data bits) for one bit period; STATUS bit2 SHALL read 1.
REQ-029 Without UART_TX_PARITY_EN, the frame SHALL be 10 bits and STATUS bit2 SHALL read 0.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum, register offsets (TXDATA_OFF, STATUS_OFF, BAUDDIV_OFF) and the STATUS bit positions.
REQ-031 Sub-module uart_baud_gen SHALL hold the bit-period counter; inputs clk, rst_n, restart, div[15:0]; output tick, high on the last cycle of each period.

Verification
REQ-032 Set BAUDDIV=3, write TXDATA=0xA5 with mask 4'b0001 -> tx_o low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles; tx_done_o pulses once; total 40 cycles.
REQ-033 Write 0x11, then 0x22 during the start bit, then 0x33 while hold_full=1 -> two frames back-to-back with no gap; 0x33 never appears; STATUS reads 0x3 during frame 1.
REQ-034 Assert rst_n=0 for 1 cycle in the middle of data bit 4 -> tx_o=1 next cycle, STATUS=0, BAUDDIV reads 867.
REQ-035 Write TXDATA with mask 4'b1110 -> no frame; write BAUDDIV=0 then TXDATA 0xFF -> 1-cycle bits, 10-cycle frame.
REQ-036 With UART_TX_PARITY_EN defined and BAUDDIV=1, send 0x07 -> parity bit 1, 22-cycle frame; with 0x03 -> parity bit 0.
